mux_rr: RTL

Parametrised, registered N-channel data multiplexer with manual and round-robin scan modes, successor to the combinational 2:1 8-bit selector. It sits in front of shared datapath consumers (ALU operand bus, debug/observation port) where several WIDTH-bit sources must be presented one at a time. The output is registered with a valid flag and the channel tag. An out-of-range select gives a defined zero output, never X.

---
 rtl/mux_pkg.sv | 12 +
 rtl/rr_next_sel.sv | 27 ++
 rtl/mux_rr.sv | 93 +++++++++
 3 files changed

// File: rtl/mux_pkg.sv
// Shared constants for the registered round-robin channel multiplexer.
package mux_pkg;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // Reset pointer sits on the last channel so the first scan pick is channel 0.
  function automatic int unsigned rst_ptr(input int unsigned nch);
    return nch - 1;
  endfunction

endpackage

// File: rtl/rr_next_sel.sv
// Rotate-priority search: first enabled channel after ptr, wrapping, ptr itself last.
module rr_next_sel #(
  parameter int unsigned NCH  = 4,
  parameter int unsigned SELW = $clog2(NCH)
) (
  input  logic [SELW-1:0] ptr,
  input  logic [NCH-1:0]  ch_en,
  output logic [SELW-1:0] nxt,
  output logic            any
);

  logic [SELW-1:0] w_cand;

  always_comb begin
    nxt    = '0;
    any    = 1'b0;
    w_cand = '0;
    for (int unsigned k = 1; k <= NCH; k++) begin
      w_cand = SELW'((32'(ptr) + k) % NCH);
      if (!any && ch_en[w_cand]) begin
        nxt = w_cand;
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_rr.sv
// Registered N-channel data multiplexer with manual select and round-robin scan modes.
module mux_rr
  import mux_pkg::*;
#(
  parameter  int unsigned WIDTH = 8,
  parameter  int unsigned NCH   = 4,
  localparam int unsigned SELW  = $clog2(NCH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCH*WIDTH-1:0] din,
  input  logic [SELW-1:0]      sel,
  input  logic                 mode,
  input  logic [NCH-1:0]       ch_en,
  input  logic                 hold,
  output logic [WIDTH-1:0]     dout,
  output logic                 dout_valid,
  output logic [SELW-1:0]      dout_ch
);

  logic [WIDTH-1:0] w_chan [NCH];
  logic [WIDTH-1:0] r_dout,  w_dout;
  logic             r_valid, w_valid;
  logic [SELW-1:0]  r_ch,    w_ch;
  logic [SELW-1:0]  r_ptr,   w_ptr;
  logic [SELW-1:0]  w_nxt;
  logic             w_any;
  logic             w_sel_ok;

  for (genvar k = 0; k < NCH; k++) begin : g_chan
    assign w_chan[k] = din[k*WIDTH +: WIDTH];
  end

  rr_next_sel #(
    .NCH  (NCH),
    .SELW (SELW)
  ) u_rr_next_sel (
    .ptr   (r_ptr),
    .ch_en (ch_en),
    .nxt   (w_nxt),
    .any   (w_any)
  );

  assign w_sel_ok = (32'(sel) < NCH);

  // Next-state selection; hold leaves every register untouched.
  always_comb begin
    w_dout  = r_dout;
    w_valid = r_valid;
    w_ch    = r_ch;
    w_ptr   = r_ptr;
    if (!hold) begin
      if (mode == MODE_MANUAL) begin
        if (w_sel_ok) begin
          w_dout  = w_chan[sel];
          w_ch    = sel;
          w_valid = 1'b1;
          w_ptr   = sel;
        end else begin
          w_dout  = '0;
          w_ch    = '0;
          w_valid = 1'b0;
        end
      end else if (w_any) begin
        w_dout  = w_chan[w_nxt];
        w_ch    = w_nxt;
        w_valid = 1'b1;
        w_ptr   = w_nxt;
      end else begin
        w_valid = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dout  <= '0;
      r_valid <= 1'b0;
      r_ch    <= '0;
      r_ptr   <= SELW'(rst_ptr(NCH));
    end else begin
      r_dout  <= w_dout;
      r_valid <= w_valid;
      r_ch    <= w_ch;
      r_ptr   <= w_ptr;
    end
  end

  assign dout       = r_dout;
  assign dout_valid = r_valid;
  assign dout_ch    = r_ch;

endmodule
